// File: rtl/tpseqsys_pio_pkg.sv
// rtl/tpseqsys_pio_pkg.sv - shared register offsets and edge encodings for the PIO blocks
package tpseqsys_pio_pkg;

  localparam int PIO_DATA_W = 32;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic [PIO_DATA_W-1:0] edge_select(
    input int                    kind,
    input logic [PIO_DATA_W-1:0] cur,
    input logic [PIO_DATA_W-1:0] last
  );
    case (kind)
      EDGE_FALLING: return ~cur & last;
      EDGE_ANY:     return cur ^ last;
      default:      return cur & ~last;
    endcase
  endfunction

endpackage

// File: rtl/tpseqsys_sync_chain.sv
// rtl/tpseqsys_sync_chain.sv - WIDTH x STAGES flop synchroniser for asynchronous inputs
module tpseqsys_sync_chain #(
  parameter int WIDTH  = 2,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_bits,
  output logic [WIDTH-1:0] sync_bits
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= async_bits;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign sync_bits = stage[STAGES-1];

endmodule

// File: rtl/tpseqsys_gpio_in_capture.sv
// rtl/tpseqsys_gpio_in_capture.sv - Avalon-MM input PIO with sticky edge capture and maskable irq
// GPIO_IN_BITCLR_EN: edge_capture writes are write-1-to-clear instead of clear-all.
module tpseqsys_gpio_in_capture
  import tpseqsys_pio_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [PIO_DATA_W-1:0] writedata,
  input  logic [WIDTH-1:0]      in_port,
  output logic [PIO_DATA_W-1:0] readdata,
  output logic                  irq
);

  logic [WIDTH-1:0]     data_in;
  logic [WIDTH-1:0]     prev;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     edge_capture;
  logic [WIDTH-1:0]     edge_vec;
  logic [WIDTH-1:0]     clr_bits;
  logic [SYNC_STAGES:0] prime_sr;
  logic                 primed;
  logic                 wr_en;
  logic                 cap_clr;

  tpseqsys_sync_chain #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_bits (in_port),
    .sync_bits  (data_in)
  );

  // Priming follows the synchroniser fill so that the zeros loaded by reset
  // never look like an edge against a high input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prime_sr <= '0;
    else          prime_sr <= {prime_sr[SYNC_STAGES-1:0], 1'b1};
  end

  assign primed = prime_sr[SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev <= '0;
    else          prev <= data_in;
  end

  assign edge_vec = primed ? WIDTH'(edge_select(EDGE_TYPE, PIO_DATA_W'(data_in), PIO_DATA_W'(prev)))
                           : '0;

  assign wr_en   = chipselect & ~write_n;
  assign cap_clr = wr_en && (address == PIO_ADDR_EDGECAP);

`ifdef GPIO_IN_BITCLR_EN
  assign clr_bits = writedata[WIDTH-1:0];
`else
  assign clr_bits = '1;
`endif

  generate
    if (WIDTH < PIO_DATA_W) begin : g_wdata_hi
      logic unused_wdata_hi;
      assign unused_wdata_hi = ^writedata[PIO_DATA_W-1:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_en && (address == PIO_ADDR_IRQMASK)) begin
      irq_mask <= writedata[WIDTH-1:0];
    end
  end

  // A new edge is ORed in after the clear, so the set wins on a collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edge_capture <= '0;
    else          edge_capture <= (edge_capture & ~(cap_clr ? clr_bits : '0)) | edge_vec;
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA:    readdata = PIO_DATA_W'(data_in);
      PIO_ADDR_IRQMASK: readdata = PIO_DATA_W'(irq_mask);
      PIO_ADDR_EDGECAP: readdata = PIO_DATA_W'(edge_capture);
      default:          readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_tpseqsys_gpio_in_capture.sv
// tb/tb_tpseqsys_gpio_in_capture.sv - directed bench for tpseqsys_gpio_in_capture (rising and any-edge builds)
module tb_tpseqsys_gpio_in_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [1:0]  in0;
  logic [1:0]  in2;
  logic [31:0] rd0;
  logic [31:0] rd2;
  logic        irq0;
  logic        irq2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tpseqsys_gpio_in_capture #(
    .WIDTH       (2),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0)
  ) dut0 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in0),
    .readdata   (rd0),
    .irq        (irq0)
  );

  tpseqsys_gpio_in_capture #(
    .WIDTH       (2),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (2)
  ) dut2 (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in2),
    .readdata   (rd2),
    .irq        (irq2)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(tag, rd0, exp);
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in0        = 2'b11;
    in2        = 2'b00;

    // Reset with inputs held high, then release
    tick(3);
    rd_chk("reset_data", 2'd0, 32'h0);
    check("reset_irq", 32'(irq0), 32'h0);
    reset_n = 1'b1;
    tick(1);
    rd_chk("sync_1clk", 2'd0, 32'h0);
    tick(1);
    rd_chk("sync_2clk", 2'd0, 32'h3);
    tick(5);
    rd_chk("no_spurious_cap", 2'd3, 32'h0);
    check("no_spurious_irq", 32'(irq0), 32'h0);

    // Rising edge on bit 0 with mask=1
    in0 = 2'b00;
    tick(4);
    rd_chk("fall_ignored", 2'd3, 32'h0);
    wr(2'd2, 32'h1);
    rd_chk("mask_readback", 2'd2, 32'h1);
    in0 = 2'b01;
    tick(2);
    rd_chk("cap_not_yet", 2'd3, 32'h0);
    tick(1);
    rd_chk("cap_cycle3", 2'd3, 32'h1);
    check("irq_same_cycle", 32'(irq0), 32'h1);
    wr(2'd3, 32'h1);
    rd_chk("cap_cleared", 2'd3, 32'h0);
    check("irq_cleared", 32'(irq0), 32'h0);

    // Same edge with mask=0, then unmask
    wr(2'd2, 32'h0);
    in0 = 2'b00;
    tick(4);
    in0 = 2'b01;
    tick(3);
    rd_chk("cap_masked", 2'd3, 32'h1);
    check("irq_masked", 32'(irq0), 32'h0);
    wr(2'd2, 32'h1);
    check("irq_after_unmask", 32'(irq0), 32'h1);

    // Both bits captured, then clear behaviour
    in0 = 2'b00;
    tick(4);
    in0 = 2'b11;
    tick(4);
    rd_chk("cap_both", 2'd3, 32'h3);
    wr(2'd2, 32'h2);
    wr(2'd3, 32'h1);
`ifdef GPIO_IN_BITCLR_EN
    rd_chk("bitclr_w1", 2'd3, 32'h2);
    check("bitclr_irq", 32'(irq0), 32'h1);
    wr(2'd3, 32'h0);
    rd_chk("bitclr_w0", 2'd3, 32'h2);
`else
    rd_chk("clrall_w1", 2'd3, 32'h0);
    check("clrall_irq", 32'(irq0), 32'h0);
    wr(2'd3, 32'h0);
    rd_chk("clrall_w0", 2'd3, 32'h0);
`endif
    wr(2'd3, 32'h3);
    rd_chk("clr_both", 2'd3, 32'h0);

    // Clear collides with a new rising edge on bit 0: set wins
    in0 = 2'b00;
    tick(4);
    rd_chk("fall_ignored2", 2'd3, 32'h0);
    in0 = 2'b01;
    tick(2);
    wr(2'd3, 32'h3);
    rd_chk("set_wins", 2'd3, 32'h1);
    wr(2'd3, 32'h3);
    rd_chk("set_wins_clr", 2'd3, 32'h0);

    // Any-edge instance: bit 1 high then low, cleared in between
    address = 2'd3;
    #1;
    check("any_idle", rd2, 32'h0);
    in2 = 2'b10;
    tick(3);
    address = 2'd3;
    #1;
    check("any_rise", rd2, 32'h2);
    wr(2'd3, 32'h3);
    address = 2'd3;
    #1;
    check("any_cleared", rd2, 32'h0);
    in2 = 2'b00;
    tick(3);
    address = 2'd3;
    #1;
    check("any_fall", rd2, 32'h2);
    check("rise_only_unaffected", rd0, 32'h0);
    wr(2'd3, 32'h3);

    // Writes to read-only and reserved offsets have no effect
    wr(2'd2, 32'h1);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_chk("reserved_reads0", 2'd1, 32'h0);
    rd_chk("data_unchanged", 2'd0, 32'h1);
    rd_chk("mask_unchanged", 2'd2, 32'h1);
    rd_chk("cap_unchanged", 2'd3, 32'h0);
    tick(1);

    // Reset mid-operation
    in0 = 2'b00;
    tick(4);
    in0 = 2'b01;
    tick(3);
    check("pre_reset_irq", 32'(irq0), 32'h1);
    reset_n = 1'b0;
    rd_chk("reset_cap", 2'd3, 32'h0);
    check("reset_irq_mid", 32'(irq0), 32'h0);
    rd_chk("reset_mask", 2'd2, 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(5);
    rd_chk("post_reset_data", 2'd0, 32'h1);
    rd_chk("post_reset_cap", 2'd3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
